apb_master_bridge: RTL
======================

# apb_master_bridge

Single-outstanding APB requester between the multicycle core's load/store unit and the APB memory slave. Accepts one word request from the core with a valid/ready handshake and drives a compliant SETUP/ACCESS APB transfer (psel, penable, pwrite, paddr, pwdata). It waits for pready, returns read data or a completion to the core as a one-cycle response pulse, and flags misaligned addresses and stalled slaves as errors.

## Interface
- DATA_LENGTH, 32, data width (core and APB).
- ADDRESS_LENGTH, 12, byte address width.
- TIMEOUT_CYCLES, 16, ACCESS cycles without pready before error; 0 disables timeout.
- from_top_clk  in  1  clock, all logic on rising edge.
- from_top_rst  in  1  reset; **one clock; reset is synchronous and active-high**.
- core_req_valid  in  1  core request present.
- core_req_ready  out  1  bridge can accept a request this cycle.
- core_req_write  in  1  1 = write, 0 = read.
- core_req_addr  in  ADDRESS_LENGTH  byte address, word aligned.
- core_req_wdata  in  DATA_LENGTH  write data.
- core_rsp_valid  out  1  one-cycle completion pulse.
- core_rsp_rdata  out  DATA_LENGTH  read data, valid with core_rsp_valid.
- core_rsp_err  out  1  error flag, valid with core_rsp_valid.
- psel, penable, pwrite  out  1 each  APB controls.
- paddr  out  ADDRESS_LENGTH  APB address.
- pwdata  out  DATA_LENGTH  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_LENGTH  slave read data.

## Operation
- States: IDLE, SETUP, ACCESS, RESP. All outputs registered except core_req_ready = (state==IDLE || state==RESP).
- Accept when core_req_valid && core_req_ready. Latch write, addr, wdata into paddr/pwrite/pwdata.
  - If addr[1:0]==0, go to SETUP.
  - If addr[1:0]!=0, go to RESP with err=1 and rdata=0. psel never asserts.
- SETUP: psel=1, penable=0, for exactly one cycle, then go to ACCESS.
- ACCESS: psel=1, penable=1. Timeout counter increments each ACCESS cycle.
  - pready=1 sampled: go to RESP with err=0. rdata=prdata for reads, 0 for writes.
  - Counter reaches TIMEOUT_CYCLES with pready=0: go to RESP with err=1, rdata=0.
  - pready and timeout in the same cycle: pready wins, err=0.
- RESP: core_rsp_valid=1 for one cycle, psel=penable=0.
  - If a new request is accepted in this cycle, next state is SETUP (or RESP if misaligned).
  - Otherwise, next state is IDLE.
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS, and hold their last value afterward.
- Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and clears on entry to SETUP.
- Requests are not queued. core_req_valid in SETUP or ACCESS is ignored; the core holds it.

## Timing
- Reset values: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, core_rsp_valid=0, core_rsp_rdata=0, core_rsp_err=0, counter=0. core_req_ready=1 in the first cycle after reset.
- Minimum aligned latency, with accept at edge 0:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - With pready=1 in cycle 2, core_rsp_valid is high in cycle 3.
  - Each wait state adds one cycle.
- Misaligned request: core_rsp_valid in the cycle after acceptance.
- Back-to-back: the accept in RESP gives a SETUP in the next cycle. Throughput is 1 transfer per 3 cycles with zero wait states.
- Timeout: err response in cycle 2+TIMEOUT_CYCLES after acceptance.
- Reset asserted mid-transfer: all state returns to reset values at that edge, psel drops, and no response is issued for the aborted request.
- core_rsp_valid never asserts for more than one consecutive cycle per request.

## Test plan
- Reset with valid=1 held: all outputs 0 during reset; ready=1 and SETUP begins only after reset deasserts.
- Write addr=0x010, wdata=0xDEADBEEF, pready=1: psel/penable sequence 10→11 in cycles 1–2; rsp_valid in cycle 3 with err=0, rdata=0.
- Read addr=0x004, pready low for 3 ACCESS cycles, prdata=0x12345678 when pready rises: rsp in cycle 6 with rdata=0x12345678, err=0.
- Misaligned read addr=0x006: psel stays 0; rsp_valid next cycle with err=1.
- TIMEOUT_CYCLES=4, pready stuck 0: err=1 response in cycle 6. Separately, pready rising in the 4th ACCESS cycle gives err=0.
- Two back-to-back reads accepted in IDLE then RESP: second psel rises the cycle after the first response. Also assert reset during ACCESS: no response, psel=0 next cycle.

Source files
------------

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB requester for the core load/store unit
//
// Takes one word request from the core (valid/ready) and runs it as an APB
// SETUP/ACCESS transfer. The result goes back to the core as a one-cycle
// response pulse. Misaligned addresses and slaves that never raise pready
// complete with core_rsp_err set.
//
// Ports:
//   from_top_clk, from_top_rst       clock, synchronous active-high reset
//   core_req_valid/ready             request handshake
//   core_req_write/addr/wdata        request payload
//   core_rsp_valid/rdata/err         one-cycle response
//   psel, penable, pwrite            APB controls
//   paddr, pwdata                    APB address and write data
//   pready, prdata                   APB slave response
module apb_master_bridge #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      from_top_clk,
  input  logic                      from_top_rst,
  input  logic                      core_req_valid,
  output logic                      core_req_ready,
  input  logic                      core_req_write,
  input  logic [ADDRESS_LENGTH-1:0] core_req_addr,
  input  logic [DATA_LENGTH-1:0]    core_req_wdata,
  output logic                      core_rsp_valid,
  output logic [DATA_LENGTH-1:0]    core_rsp_rdata,
  output logic                      core_rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_LENGTH-1:0] paddr,
  output logic [DATA_LENGTH-1:0]    pwdata,
  input  logic                      pready,
  input  logic [DATA_LENGTH-1:0]    prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // A zero timeout still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter holds the number of earlier ACCESS cycles, so the last allowed
  // ACCESS cycle is the one that sees TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                    state, state_next;
  logic [CW-1:0]             cnt, cnt_next;
  logic                      pwrite_next;
  logic [ADDRESS_LENGTH-1:0] paddr_next;
  logic [DATA_LENGTH-1:0]    pwdata_next;
  logic [DATA_LENGTH-1:0]    rdata_next;
  logic                      err_next;
  logic                      accept;
  logic                      timed_out;

  assign core_req_ready = (state == IDLE) || (state == RESP);
  assign accept         = core_req_valid && core_req_ready;
  assign timed_out      = (TIMEOUT_CYCLES != 0) && (cnt == LAST_CNT);

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pwrite_next = pwrite;
    paddr_next  = paddr;
    pwdata_next = pwdata;
    rdata_next  = core_rsp_rdata;
    err_next    = core_rsp_err;

    case (state)
      IDLE, RESP: begin
        state_next = IDLE;
        if (accept) begin
          pwrite_next = core_req_write;
          paddr_next  = core_req_addr;
          pwdata_next = core_req_wdata;
          if (core_req_addr[1:0] == 2'b00) begin
            state_next = SETUP;
          end else begin
            // Misaligned: answer directly without touching the bus.
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = '0;
          end
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (TIMEOUT_CYCLES != 0) begin
          cnt_next = cnt + CW'(1);
        end
        // pready takes priority over a timeout landing in the same cycle.
        if (pready) begin
          state_next = RESP;
          err_next   = 1'b0;
          rdata_next = pwrite ? '0 : prdata;
        end else if (timed_out) begin
          state_next = RESP;
          err_next   = 1'b1;
          rdata_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next == SETUP) begin
      cnt_next = '0;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge from_top_clk) begin
    if (from_top_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      psel           <= 1'b0;
      penable        <= 1'b0;
      pwrite         <= 1'b0;
      paddr          <= '0;
      pwdata         <= '0;
      core_rsp_valid <= 1'b0;
      core_rsp_rdata <= '0;
      core_rsp_err   <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      psel           <= (state_next == SETUP) || (state_next == ACCESS);
      penable        <= (state_next == ACCESS);
      pwrite         <= pwrite_next;
      paddr          <= paddr_next;
      pwdata         <= pwdata_next;
      core_rsp_valid <= (state_next == RESP);
      core_rsp_rdata <= rdata_next;
      core_rsp_err   <= err_next;
    end
  end

endmodule
